// File: rtl/lipsi_prog_loader_pkg.sv
// Shared definitions for the Lipsi boot/program-load controller:
// state encodings, default memory geometry and synchroniser depth.
package lipsi_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } state_e;

  localparam int DEFAULT_ADDR_W = 8;
  localparam int SYNC_STAGES    = 2;

  // The core is only released while running; every other state parks it.
  function automatic logic holds_core(state_e s);
    return (s != ST_RUN);
  endfunction

endpackage

// File: rtl/lipsi_prog_loader_if.sv
// Program-memory write port driven by the loader.
// Handshake: mem_we_o is a one-cycle valid qualifying mem_addr_o/mem_wdata_o;
// there is no ready, so the memory must accept every pulse it sees.
interface lipsi_prog_loader_if #(
  parameter int ADDR_W = 8
) ();

  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [7:0]        mem_wdata_o;

  modport master (
    output mem_we_o,
    output mem_addr_o,
    output mem_wdata_o
  );

  modport slave (
    input mem_we_o,
    input mem_addr_o,
    input mem_wdata_o
  );

endinterface

// File: rtl/lipsi_prog_loader_sync_edge.sv
// Multi-flop synchroniser for asynchronous pins with a registered
// rising-edge detector on bit 0 (sync2 & ~sync3).
module lipsi_sync_edge
  import lipsi_loader_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_sync,
  output logic         o_rise
);

  logic [W-1:0] r_stage [SYNC_STAGES];
  logic         r_prev;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_stage[i] <= '0;
      end
      r_prev <= 1'b0;
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
      r_prev <= r_stage[SYNC_STAGES-1][0];
    end
  end

  assign o_sync = r_stage[SYNC_STAGES-1];
  assign o_rise = r_stage[SYNC_STAGES-1][0] & ~r_prev;

endmodule

// File: rtl/lipsi_prog_loader.sv
// Boot/program-load controller: holds the Lipsi core in reset while a byte
// stream is written to program memory, then releases it to run.
module lipsi_prog_loader
  import lipsi_loader_pkg::*;
#(
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter bit AUTO_RUN = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                load_mode_i,
  input  logic                strobe_i,
  input  logic [7:0]          data_i,
  input  logic                cpu_halt_i,
  lipsi_prog_loader_if.master mem_if,
  output logic                cpu_reset_o,
  output logic [ADDR_W:0]     byte_count_o,
  output logic                overflow_o,
  output logic [1:0]          state_o
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  logic       w_load_s;
  logic       w_strobe_rise;
  logic [7:0] w_data_s;
  logic       w_load_rise_unused;
  logic       w_strobe_lvl_unused;
  logic       w_data_rise_unused;

  lipsi_sync_edge #(.W(1)) u_sync_load (
    .clock  (clock),
    .reset  (reset),
    .i_d    (load_mode_i),
    .o_sync (w_load_s),
    .o_rise (w_load_rise_unused)
  );

  lipsi_sync_edge #(.W(1)) u_sync_strobe (
    .clock  (clock),
    .reset  (reset),
    .i_d    (strobe_i),
    .o_sync (w_strobe_lvl_unused),
    .o_rise (w_strobe_rise)
  );

  lipsi_sync_edge #(.W(8)) u_sync_data (
    .clock  (clock),
    .reset  (reset),
    .i_d    (data_i),
    .o_sync (w_data_s),
    .o_rise (w_data_rise_unused)
  );

  state_e            r_state,     w_state_nxt;
  logic              r_cpu_reset, w_cpu_reset_nxt;
  logic              r_we,        w_we_nxt;
  logic [ADDR_W-1:0] r_addr,      w_addr_nxt;
  logic [7:0]        r_wdata,     w_wdata_nxt;
  logic [ADDR_W:0]   r_count,     w_count_nxt;
  logic              r_ovf,       w_ovf_nxt;
  // Armed by reset only: AUTO_RUN applies to the first IDLE visit after reset.
  logic              r_boot,      w_boot_nxt;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cpu_reset <= 1'b1;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_count     <= '0;
      r_ovf       <= 1'b0;
      r_boot      <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_cpu_reset <= w_cpu_reset_nxt;
      r_we        <= w_we_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_count     <= w_count_nxt;
      r_ovf       <= w_ovf_nxt;
      r_boot      <= w_boot_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_we_nxt    = 1'b0;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_count_nxt = r_count;
    w_ovf_nxt   = r_ovf;
    w_boot_nxt  = r_boot;

    case (r_state)
      ST_IDLE: begin
        if (w_load_s) begin
          w_state_nxt = ST_LOAD;
        end else if (AUTO_RUN && r_boot) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_LOAD: begin
        if (w_strobe_rise) begin
          if (r_count < DEPTH) begin
            w_we_nxt    = 1'b1;
            w_addr_nxt  = r_count[ADDR_W-1:0];
            w_wdata_nxt = w_data_s;
            w_count_nxt = r_count + 1'b1;
          end else begin
            w_ovf_nxt = 1'b1;
          end
        end
        // A byte arriving with the falling load request still counts here.
        if (!w_load_s) begin
          w_state_nxt = (w_count_nxt != '0) ? ST_RUN : ST_IDLE;
        end
      end
      ST_RUN: begin
        if (w_load_s) begin
          w_state_nxt = ST_LOAD;
        end else if (cpu_halt_i) begin
          w_state_nxt = ST_HALT;
        end
      end
      ST_HALT: begin
        if (w_load_s) begin
          w_state_nxt = ST_LOAD;
        end
      end
    endcase

    if (w_state_nxt == ST_LOAD && r_state != ST_LOAD) begin
      w_addr_nxt  = '0;
      w_count_nxt = '0;
      w_ovf_nxt   = 1'b0;
    end

    if (r_state == ST_IDLE && w_state_nxt != ST_IDLE) begin
      w_boot_nxt = 1'b0;
    end

    w_cpu_reset_nxt = holds_core(w_state_nxt);
  end

  assign mem_if.mem_we_o    = r_we;
  assign mem_if.mem_addr_o  = r_addr;
  assign mem_if.mem_wdata_o = r_wdata;
  assign cpu_reset_o        = r_cpu_reset;
  assign byte_count_o       = r_count;
  assign overflow_o         = r_ovf;
  assign state_o            = r_state;

endmodule

// File: tb/tb_lipsi_prog_loader.sv
// Directed-plus-random bench for lipsi_prog_loader with a small memory
// (ADDR_W=2) so that overflow is reached quickly.
module tb_lipsi_prog_loader;

  localparam int AW    = 2;
  localparam int DEPTH = 4;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_HALT = 2'd3;

  logic          clock;
  logic          reset;
  logic          load_mode_i;
  logic          strobe_i;
  logic [7:0]    data_i;
  logic          cpu_halt_i;
  logic          cpu_reset_o;
  logic [AW:0]   byte_count_o;
  logic          overflow_o;
  logic [1:0]    state_o;

  lipsi_prog_loader_if #(.ADDR_W(AW)) mem_if ();

  lipsi_prog_loader #(.ADDR_W(AW), .AUTO_RUN(1'b1)) dut (
    .clock        (clock),
    .reset        (reset),
    .load_mode_i  (load_mode_i),
    .strobe_i     (strobe_i),
    .data_i       (data_i),
    .cpu_halt_i   (cpu_halt_i),
    .mem_if       (mem_if),
    .cpu_reset_o  (cpu_reset_o),
    .byte_count_o (byte_count_o),
    .overflow_o   (overflow_o),
    .state_o      (state_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: what the loader should be doing, at transaction level.
  logic [1:0] m_state = S_IDLE;
  int         m_count = 0;
  bit         m_ovf   = 1'b0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, "_state"}, 32'(state_o), 32'(m_state));
    check({tag, "_cpu_reset"}, 32'(cpu_reset_o), (m_state == S_RUN) ? 32'd0 : 32'd1);
    check({tag, "_count"}, 32'(byte_count_o), m_count);
    check({tag, "_overflow"}, 32'(overflow_o), 32'(m_ovf));
  endtask

  // One byte over the strobe pins; a write is expected only in LOAD below depth.
  task automatic send_byte(input logic [7:0] d);
    data_i = d;
    tick();
    tick();
    strobe_i = 1'b1;
    tick();
    tick();
    check("we_before_latency", 32'(mem_if.mem_we_o), 32'd0);
    tick();
    if (m_state == S_LOAD && m_count < DEPTH) begin
      check("we_pulse", 32'(mem_if.mem_we_o), 32'd1);
      check("wr_addr", 32'(mem_if.mem_addr_o), m_count);
      check("wr_data", 32'(mem_if.mem_wdata_o), 32'(d));
      m_count++;
    end else begin
      check("we_suppressed", 32'(mem_if.mem_we_o), 32'd0);
      if (m_state == S_LOAD) m_ovf = 1'b1;
    end
    check_status("after_byte");
    tick();
    check("we_one_cycle", 32'(mem_if.mem_we_o), 32'd0);
    strobe_i = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic enter_load();
    load_mode_i = 1'b1;
    tick();
    tick();
    check("load_sync_delay", 32'(state_o), 32'(m_state));
    tick();
    m_state = S_LOAD;
    m_count = 0;
    m_ovf   = 1'b0;
    check_status("enter_load");
  endtask

  task automatic leave_load();
    load_mode_i = 1'b0;
    tick();
    tick();
    tick();
    m_state = (m_count > 0) ? S_RUN : S_IDLE;
    check_status("leave_load");
  endtask

  task automatic do_halt();
    cpu_halt_i = 1'b1;
    tick();
    m_state = S_HALT;
    check_status("halt");
    cpu_halt_i = 1'b0;
    tick();
    check_status("halt_held");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    reset       = 1'b1;
    load_mode_i = 1'b0;
    strobe_i    = 1'b0;
    data_i      = 8'h00;
    cpu_halt_i  = 1'b0;
    tick();
    tick();
    tick();
    check_status("reset");
    check("reset_we", 32'(mem_if.mem_we_o), 32'd0);
    check("reset_addr", 32'(mem_if.mem_addr_o), 32'd0);
    check("reset_wdata", 32'(mem_if.mem_wdata_o), 32'd0);
    reset = 1'b0;
    tick();
    m_state = S_RUN;
    check_status("auto_run");

    // Basic three-byte program.
    enter_load();
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    leave_load();

    // Overrun the 4-byte memory; overflow is sticky until the next load.
    enter_load();
    for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(0, 255)));
    leave_load();
    tick();
    check_status("ovf_sticky_run");
    enter_load();
    send_byte(8'($urandom_range(0, 255)));
    send_byte(8'($urandom_range(0, 255)));
    leave_load();

    // Halt parks the core; strobes are ignored until a reload.
    do_halt();
    send_byte(8'($urandom_range(0, 255)));
    send_byte(8'($urandom_range(0, 255)));
    enter_load();

    // Strobe edge and load release in the same cycle.
    data_i = 8'hA5;
    tick();
    tick();
    load_mode_i = 1'b0;
    strobe_i    = 1'b1;
    tick();
    tick();
    check("same_cycle_early", 32'(mem_if.mem_we_o), 32'd0);
    tick();
    check("same_cycle_we", 32'(mem_if.mem_we_o), 32'd1);
    check("same_cycle_addr", 32'(mem_if.mem_addr_o), 32'd0);
    check("same_cycle_data", 32'(mem_if.mem_wdata_o), 32'hA5);
    m_count = 1;
    m_state = S_RUN;
    check_status("same_cycle");
    tick();
    strobe_i = 1'b0;
    tick();
    tick();
    tick();

    // Empty load falls back to IDLE and stays there.
    enter_load();
    leave_load();
    for (int i = 0; i < 4; i++) tick();
    check_status("idle_parked");
    send_byte(8'($urandom_range(0, 255)));

    // Load request wins over halt in RUN; halt is ignored in LOAD.
    enter_load();
    send_byte(8'($urandom_range(0, 255)));
    leave_load();
    load_mode_i = 1'b1;
    tick();
    tick();
    check("prio_still_run", 32'(state_o), 32'(S_RUN));
    cpu_halt_i = 1'b1;
    tick();
    m_state = S_LOAD;
    m_count = 0;
    m_ovf   = 1'b0;
    check_status("prio_load");
    tick();
    check_status("halt_ignored_in_load");
    cpu_halt_i = 1'b0;

    // Randomised loads of varying length with optional halts.
    for (int k = 0; k < 5; k++) begin
      n = int'($urandom_range(0, 6));
      for (int i = 0; i < n; i++) begin
        send_byte(8'($urandom_range(0, 255)));
        for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick();
      end
      leave_load();
      if (m_state == S_RUN && $urandom_range(0, 1) == 1) do_halt();
      enter_load();
    end

    // Reset in the middle of a load.
    send_byte(8'($urandom_range(0, 255)));
    send_byte(8'($urandom_range(0, 255)));
    reset       = 1'b1;
    load_mode_i = 1'b0;
    tick();
    m_state = S_IDLE;
    m_count = 0;
    m_ovf   = 1'b0;
    check_status("mid_load_reset");
    check("mid_load_reset_we", 32'(mem_if.mem_we_o), 32'd0);
    check("mid_load_reset_addr", 32'(mem_if.mem_addr_o), 32'd0);
    reset = 1'b0;
    tick();
    m_state = S_RUN;
    check_status("rerun_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lipsi_prog_loader.md
Name: lipsi_prog_loader

Overview:
- Boot/program-load controller sequencing the Lipsi processor core from the TinyTapeout pins.
- Accepts a byte stream over an asynchronous strobe handshake while the core is held in reset, and writes the bytes to program memory at incrementing addresses.
- Releases the core to run once loading ends, and parks it again on halt or on a new load request.
- Sits between the top-level pin wrapper and the core/program-memory write port.

Parameters:
- ADDR_W, 8, program memory address width; depth = 2**ADDR_W bytes.
- AUTO_RUN, 1, if 1 the core runs the resident program after reset when no load is requested; if 0 it waits in IDLE.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- load_mode_i  in  1  asynchronous pin: high requests program load.
- strobe_i  in  1  asynchronous pin: each rising edge delivers one byte.
- data_i  in  8  asynchronous byte; stable ≥1 clock before strobe_i rises and until it falls.
- cpu_halt_i  in  1  core halt indication, synchronous.
- mem_we_o  out  1  program memory write enable, one-cycle pulse.
- mem_addr_o  out  ADDR_W  write address.
- mem_wdata_o  out  8  write data.
- cpu_reset_o  out  1  holds the core in reset when high.
- byte_count_o  out  ADDR_W+1  bytes written in the current/last load.
- overflow_o  out  1  sticky: load exceeded memory depth.
- state_o  out  2  current state encoding, for debug pins.

Behaviour:
- Clock and reset: one clock `clock`. Reset `reset` is synchronous and active-high.
- Reset values:
  - state = IDLE, cpu_reset_o = 1.
  - mem_we_o = 0, mem_addr_o = 0, mem_wdata_o = 0.
  - byte_count_o = 0, overflow_o = 0.
  - Synchroniser flops = 0.
- Input conditioning:
  - load_mode_i, strobe_i and data_i each pass through 2-flop synchronisers.
  - The strobe rising edge = sync2 & ~sync3.
- States (state_o): IDLE=0, LOAD=1, RUN=2, HALT=3.
- cpu_reset_o is registered: 1 in IDLE/LOAD/HALT, 0 in RUN. It changes on the edge that enters or leaves RUN.
- IDLE transitions:
  - load_s=1 -> LOAD.
  - Else if AUTO_RUN=1 -> RUN.
  - Else remain in IDLE.
- Entering LOAD (from any state): mem_addr_o := 0, byte_count_o := 0, overflow_o := 0.
- LOAD, per detected strobe edge:
  - If byte_count_o < 2**ADDR_W: on the next edge mem_we_o := 1 for exactly one cycle, mem_wdata_o := synced data, mem_addr_o := byte_count_o[ADDR_W-1:0]. byte_count_o increments on the same edge.
  - Else: no write, overflow_o := 1 (sticky until next LOAD entry or reset).
- Write latency: mem_we_o is high in the cycle after the 3rd clock edge at which strobe_i is sampled high.
  - Edge 1 loads sync1, edge 2 sync2, edge 3 registers the write.
  - mem_addr_o/mem_wdata_o hold their values after the pulse.
- LOAD exit on load_s=0:
  - byte_count_o > 0 -> RUN.
  - byte_count_o = 0 -> IDLE. IDLE is then not re-evaluated for AUTO_RUN until the next reset; stays IDLE until load_s=1.
- Strobe edge and load_s falling in the same cycle: the byte is still written, then the RUN/IDLE decision uses the incremented count.
- RUN transitions:
  - load_s=1 -> LOAD; cpu_reset_o rises on that edge (reload mid-run).
  - Else cpu_halt_i=1 -> HALT.
  - load_s has priority over cpu_halt_i.
- HALT transitions: load_s=1 -> LOAD. cpu_halt_i is ignored outside RUN. HALT never returns to RUN without a load.
- Strobe edges outside LOAD are ignored: no write, no count change.
- Reset mid-LOAD: returns to IDLE with all reset values. Partially loaded memory contents are not cleared.
- Wrap: mem_addr_o never wraps. Writes stop at address 2**ADDR_W-1.

Decomposition:
- Package lipsi_loader_pkg holds:
  - state encodings IDLE/LOAD/RUN/HALT (2-bit),
  - default ADDR_W,
  - synchroniser depth constant SYNC_STAGES=2.
- One sub-module: lipsi_sync_edge. It is the 2-flop synchroniser plus a registered rising-edge detector. It is instantiated for strobe_i, and as a plain synchroniser for load_mode_i and data_i.

Test Plan:
- Reset with AUTO_RUN=1, load_mode_i=0 -> cpu_reset_o=1 after reset, state IDLE. One cycle later state RUN, cpu_reset_o=0. byte_count_o=0, overflow_o=0.
- load_mode_i=1, then 3 strobes with data 0x12, 0x34, 0x56 -> three 1-cycle mem_we_o pulses at addr 0,1,2 with those data, each 3 edges after strobe sampled high. byte_count_o=3. Drop load_mode_i -> RUN, cpu_reset_o=0.
- ADDR_W=2, 5 strobes in LOAD -> writes at addr 0..3 only. byte_count_o=4, overflow_o=1. No 5th mem_we_o. A new LOAD entry clears overflow_o.
- RUN, assert cpu_halt_i -> HALT, cpu_reset_o=1. Strobes in HALT produce no writes. load_mode_i=1 -> LOAD, count reset to 0.
- In LOAD, strobe edge detected in the same cycle load_s falls, with data 0xA5 and count previously 0 -> write 0xA5 at addr 0, byte_count_o=1, state RUN. Repeat with no strobe and count 0 -> state IDLE, cpu_reset_o stays 1.
- Assert reset after 2 bytes mid-LOAD -> next cycle state IDLE, byte_count_o=0, mem_addr_o=0, mem_we_o=0, cpu_reset_o=1.
